// File: rtl/wb_pkg.sv
// Shared write-back encodings: result-source select and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } res_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_if.sv
// M-to-W bundle: M-stage inputs, W-stage results and retire count.
interface wb_stage_if #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
);
  logic               StallW;
  logic               FlushW;
  logic               ValidM;
  logic               RegWriteM;
  logic [1:0]         ResultSrcM;
  logic [2:0]         Funct3M;
  logic [XLEN-1:0]    ALUResultM;
  logic [XLEN-1:0]    ReadDataM;
  logic [XLEN-1:0]    PCPlus4M;
  logic [XLEN-1:0]    ImmExtM;
  logic [RADDR_W-1:0] RdM;
  logic               ValidW;
  logic               RegWriteW;
  logic [RADDR_W-1:0] RdW;
  logic [XLEN-1:0]    ResultW;
  logic [CNT_W-1:0]   InstRetW;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM,
    output ResultSrcM, Funct3M, ALUResultM,
    output ReadDataM, PCPlus4M, ImmExtM, RdM,
    input  ValidW, RegWriteW, RdW,
    input  ResultW, InstRetW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM,
    input  ResultSrcM, Funct3M, ALUResultM,
    input  ReadDataM, PCPlus4M, ImmExtM, RdM,
    output ValidW, RegWriteW, RdW,
    output ResultW, InstRetW
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// load_ext: aligns the addressed field of a memory word and extends it.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]            data,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            ext
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic [1:0]       size;
  logic             uns;
  logic [OFF_W-1:0] mask;
  logic [OFF_W-1:0] aligned;
  logic [XLEN-1:0]  shifted;

  always_comb begin
    uns  = funct3[2];
    size = funct3[1:0];
    // RV32 has no doubleword: LD and 111 collapse to a word
    if (XLEN == 32 && size == F3_LD[1:0])
      size = F3_LW[1:0];
    mask    = '1;
    mask    = mask << size;
    aligned = off & mask;
    shifted = data >> {aligned, 3'b000};
    ext     = shifted;
    unique case (size)
      2'b00: begin
        if (uns) ext = XLEN'(shifted[7:0]);
        else     ext = XLEN'($signed(shifted[7:0]));
      end
      2'b01: begin
        if (uns) ext = XLEN'(shifted[15:0]);
        else     ext = XLEN'($signed(shifted[15:0]));
      end
      2'b10: begin
        if (uns) ext = XLEN'(shifted[31:0]);
        else     ext = XLEN'($signed(shifted[31:0]));
      end
      2'b11: ext = shifted;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: W register, result select and retire counter.
// Define WB_LOAD_EXT_EN to align/extend load data in this stage.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input logic       clock,
  input logic       reset,
  wb_stage_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic               valid_q;
  logic               regwr_q;
  logic [RADDR_W-1:0] rd_q;
  res_src_t           src_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    rdata_q;
  logic [XLEN-1:0]    pc4_q;
  logic [XLEN-1:0]    imm_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    load_val;
  logic [XLEN-1:0]    result;

  // flush clears only the control fields; data is don't-care
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      rd_q    <= '0;
      src_q   <= RES_ALU;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
    end else if (bus.FlushW) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      rd_q    <= '0;
    end else if (!bus.StallW) begin
      valid_q <= bus.ValidM;
      regwr_q <= bus.RegWriteM;
      rd_q    <= bus.RdM;
      src_q   <= res_src_t'(bus.ResultSrcM);
      alu_q   <= bus.ALUResultM;
      rdata_q <= bus.ReadDataM;
      pc4_q   <= bus.PCPlus4M;
      imm_q   <= bus.ImmExtM;
    end
  end

  // stall+flush squashes W, so the stall gate also covers that case
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (valid_q && !bus.StallW)
      cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] f3_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      f3_q <= '0;
    else if (!bus.FlushW && !bus.StallW)
      f3_q <= bus.Funct3M;
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .data   (rdata_q),
    .off    (alu_q[OFF_W-1:0]),
    .funct3 (f3_q),
    .ext    (load_val)
  );
`else
  logic [2:0] unused_f3;

  assign unused_f3 = bus.Funct3M;
  assign load_val  = rdata_q;
`endif

  always_comb begin
    result = alu_q;
    unique case (src_q)
      RES_ALU:  result = alu_q;
      RES_LOAD: result = load_val;
      RES_PC4:  result = pc4_q;
      RES_IMM:  result = imm_q;
    endcase
  end

  assign bus.ValidW    = valid_q;
  assign bus.RegWriteW = regwr_q & valid_q & (rd_q != '0);
  assign bus.RdW       = rd_q;
  assign bus.ResultW   = result;
  assign bus.InstRetW  = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table with scoreboard, plus stall/flush/reset sequences.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 64;
`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam logic [63:0] RD = 64'h1234_5678_9ABC_DEF0;

  typedef struct {
    logic        v;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [63:0] pc4;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [63:0] e_res;
    logic        e_we;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        valid;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        w_valid_m = 1'b0;
  logic [63:0] cnt_m = '0;
  vec_t        tv[$];
  exp_t        sb[$];

  wb_stage_if #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)
  ) bus ();

  wb_stage #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic v, rw, input logic [1:0] src,
    input logic [2:0] f3, input logic [63:0] alu,
    input logic [63:0] pc4, imm, input logic [4:0] rd,
    input logic [63:0] e_res, input logic e_we
  );
    vec_t t;
    t.v = v; t.rw = rw; t.src = src; t.f3 = f3;
    t.alu = alu; t.rdata = RD; t.pc4 = pc4;
    t.imm = imm; t.rd = rd; t.e_res = e_res;
    t.e_we = e_we;
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.ValidM     = t.v;
    bus.RegWriteM  = t.rw;
    bus.ResultSrcM = t.src;
    bus.Funct3M    = t.f3;
    bus.ALUResultM = t.alu;
    bus.ReadDataM  = t.rdata;
    bus.PCPlus4M   = t.pc4;
    bus.ImmExtM    = t.imm;
    bus.RdM        = t.rd;
  endtask

  task automatic alu_op(input logic v, input logic [4:0] rd,
                        input logic [63:0] val);
    drive(mk(v, 1'b1, 2'b00, 3'b000, val, 0, 0, rd, val, 1'b0));
  endtask

  // count rule: the instruction in W retires unless stalled
  task automatic step();
    logic old;
    old = w_valid_m;
    @(posedge clock);
    if (old && !bus.StallW) cnt_m++;
    if (bus.FlushW) w_valid_m = 1'b0;
    else if (!bus.StallW) w_valid_m = bus.ValidM;
    #1;
  endtask

  task automatic chk_w(input string n, input logic [63:0] res,
                       input logic [4:0] rd, input logic we, v);
    chk({n, "_res"}, bus.ResultW, res);
    chk({n, "_rd"}, 64'(bus.RdW), 64'(rd));
    chk({n, "_we"}, 64'(bus.RegWriteW), 64'(we));
    chk({n, "_valid"}, 64'(bus.ValidW), 64'(v));
    chk({n, "_cnt"}, bus.InstRetW, cnt_m);
  endtask

  initial begin
    exp_t e;
    logic [63:0] c0;

    tv.push_back(mk(1, 1, 2'b00, 3'b000, 64'hAABBCCDDEEFF0011,
                    0, 0, 21, 64'hAABBCCDDEEFF0011, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b000, 64'h1, 0, 0, 5,
                    EXT ? 64'hFFFFFFFFFFFFFFDE : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b100, 64'h1, 0, 0, 5,
                    EXT ? 64'hDE : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b001, 64'h6, 0, 0, 6,
                    EXT ? 64'h1234 : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b010, 64'h4, 0, 0, 7,
                    EXT ? 64'h12345678 : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b110, 64'h0, 0, 0, 8,
                    EXT ? 64'h9ABCDEF0 : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b010, 64'h0, 0, 0, 9,
                    EXT ? 64'hFFFFFFFF9ABCDEF0 : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b001, 64'h3, 0, 0, 10,
                    EXT ? 64'hFFFFFFFFFFFF9ABC : RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b011, 64'h5, 0, 0, 11,
                    RD, 1));
    tv.push_back(mk(1, 1, 2'b01, 3'b111, 64'h2, 0, 0, 12,
                    RD, 1));
    tv.push_back(mk(1, 1, 2'b10, 3'b000, 64'h0, 64'h44, 0, 1,
                    64'h44, 1));
    tv.push_back(mk(1, 1, 2'b11, 3'b000, 64'h0, 0,
                    64'h12345000, 2, 64'h12345000, 1));
    tv.push_back(mk(1, 1, 2'b00, 3'b000, 64'h5, 0, 0, 0,
                    64'h5, 0));
    tv.push_back(mk(0, 1, 2'b00, 3'b000, 64'h9, 0, 0, 7,
                    64'h9, 0));
    tv.push_back(mk(1, 0, 2'b00, 3'b000, 64'h3, 0, 0, 3,
                    64'h3, 0));

    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    alu_op(1'b0, 5'd0, 64'h0);
    repeat (2) @(posedge clock);
    #1;
    chk_w("reset", 64'h0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i]);
      sb.push_back('{res: tv[i].e_res, rd: tv[i].rd,
                     we: tv[i].e_we, valid: tv[i].v});
      step();
      e = sb.pop_front();
      chk_w($sformatf("vec%0d", i), e.res, e.rd, e.we, e.valid);
    end

    alu_op(1'b1, 5'd9, 64'h77);
    step();
    chk_w("stall_a", 64'h77, 5'd9, 1'b1, 1'b1);
    c0 = bus.InstRetW;
    bus.StallW = 1'b1;
    alu_op(1'b1, 5'd10, 64'h88);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_w($sformatf("stall%0d", k), 64'h77, 5'd9, 1'b1, 1'b1);
      chk($sformatf("stall%0d_hold", k), bus.InstRetW, c0);
    end
    bus.StallW = 1'b0;
    step();
    chk_w("stall_rel", 64'h88, 5'd10, 1'b1, 1'b1);
    chk("stall_rel_cnt", bus.InstRetW, c0 + 1);

    bus.FlushW = 1'b1;
    alu_op(1'b1, 5'd11, 64'h99);
    step();
    chk("flush_valid", 64'(bus.ValidW), 64'h0);
    chk("flush_we", 64'(bus.RegWriteW), 64'h0);
    chk("flush_rd", 64'(bus.RdW), 64'h0);
    chk("flush_cnt", bus.InstRetW, c0 + 2);
    bus.FlushW = 1'b0;

    alu_op(1'b1, 5'd12, 64'hD);
    step();
    chk_w("sf_load", 64'hD, 5'd12, 1'b1, 1'b1);
    bus.StallW = 1'b1;
    bus.FlushW = 1'b1;
    step();
    chk("sf_valid", 64'(bus.ValidW), 64'h0);
    chk("sf_we", 64'(bus.RegWriteW), 64'h0);
    chk("sf_cnt", bus.InstRetW, c0 + 2);
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;

    alu_op(1'b0, 5'd13, 64'h13);
    step();
    chk_w("bubble_in", 64'h13, 5'd13, 1'b0, 1'b0);
    alu_op(1'b1, 5'd14, 64'hE);
    step();
    chk_w("bubble_out", 64'hE, 5'd14, 1'b1, 1'b1);
    chk("bubble_cnt", bus.InstRetW, c0 + 2);

    #2;
    reset = 1'b0;
    #1;
    w_valid_m = 1'b0;
    cnt_m = '0;
    chk_w("midrst", 64'h0, 5'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    alu_op(1'b1, 5'd15, 64'hF);
    step();
    chk_w("post_rst", 64'hF, 5'd15, 1'b1, 1'b1);
    alu_op(1'b0, 5'd0, 64'h0);
    step();
    chk("post_rst_cnt", bus.InstRetW, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
